// File: rtl/inst_mem_loader.sv
// Loads a framed byte stream (len, 4*N big-endian word bytes, XOR checksum) into instruction memory.
// Word write one cycle after its 4th byte; byte_ready drops during the write cycle and outside a load.
module inst_mem_loader #(
  parameter int ADDR_W = 6
) (
  input  logic              clka,
  input  logic              rsta,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_wea,
  output logic [ADDR_W-1:0] mem_addra,
  output logic [31:0]       mem_dina,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_WRITE, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_idx;
  logic [ADDR_W-1:0]   r_last;
  logic [1:0]          r_bcnt;
  logic [31:0]         r_word;
  logic [7:0]          r_acc;
  logic                r_byte_ready;
  logic                r_mem_wea;
  logic [ADDR_W-1:0]   r_mem_addra;
  logic [31:0]         r_mem_dina;
  logic                r_cpu_hold;
  logic                r_busy;
  logic                r_done;
  logic                r_err;

  logic                w_xfer;
  logic [31:0]         w_word_nxt;
  logic [7:0]          w_acc_nxt;
  logic [ADDR_W-1:0]   w_len_lo;
  logic [ADDR_W-1:0]   w_one;

  assign w_xfer     = byte_valid & r_byte_ready;
  assign w_word_nxt = {r_word[23:0], byte_data};
  assign w_acc_nxt  = r_acc ^ byte_data;
  assign w_len_lo   = byte_data[ADDR_W-1:0];
  assign w_one      = {{(ADDR_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clka or negedge rsta) begin
    if (!rsta) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_last       <= '0;
      r_bcnt       <= '0;
      r_word       <= '0;
      r_acc        <= '0;
      r_byte_ready <= 1'b0;
      r_mem_wea    <= 1'b0;
      r_mem_addra  <= '0;
      r_mem_dina   <= '0;
      r_cpu_hold   <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_mem_wea <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            r_state      <= S_LEN;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_cpu_hold   <= 1'b1;
            r_busy       <= 1'b1;
            r_byte_ready <= 1'b1;
            r_acc        <= '0;
            r_idx        <= '0;
            r_bcnt       <= '0;
          end
        end
        S_LEN: begin
          if (w_xfer) begin
            // Storing N-1 folds the "0 means full depth" encoding into the wrap.
            r_last  <= w_len_lo - w_one;
            r_acc   <= w_acc_nxt;
            r_bcnt  <= '0;
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_xfer) begin
            r_word <= w_word_nxt;
            r_acc  <= w_acc_nxt;
            r_bcnt <= r_bcnt + 2'd1;
            if (r_bcnt == 2'd3) begin
              r_state      <= S_WRITE;
              r_byte_ready <= 1'b0;
              r_mem_wea    <= 1'b1;
              r_mem_addra  <= r_idx;
              r_mem_dina   <= w_word_nxt;
            end
          end
        end
        S_WRITE: begin
          r_idx        <= r_idx + w_one;
          r_byte_ready <= 1'b1;
          r_state      <= (r_idx == r_last) ? S_CHK : S_DATA;
        end
        S_CHK: begin
          if (w_xfer) begin
            r_byte_ready <= 1'b0;
            r_busy       <= 1'b0;
            if (byte_data == r_acc) begin
              r_state    <= S_DONE;
              r_done     <= 1'b1;
              r_cpu_hold <= 1'b0;
            end else begin
              r_state    <= S_ERR;
              r_err      <= 1'b1;
              r_cpu_hold <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign byte_ready = r_byte_ready;
  assign mem_wea    = r_mem_wea;
  assign mem_addra  = r_mem_addra;
  assign mem_dina   = r_mem_dina;
  assign cpu_hold   = r_cpu_hold;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Randomized scoreboard bench for inst_mem_loader: expected writes queued at stimulus time,
// popped by an independent monitor whenever mem_wea is seen.
module tb_inst_mem_loader;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clka = 1'b0;
  logic              rsta;
  logic              start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_wea;
  logic [ADDR_W-1:0] mem_addra;
  logic [31:0]       mem_dina;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [ADDR_W+31:0] exp_q[$];
  logic prev_xfer = 1'b0;

  inst_mem_loader #(.ADDR_W(ADDR_W)) dut (
    .clka(clka), .rsta(rsta), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .mem_wea(mem_wea),
    .mem_addra(mem_addra), .mem_dina(mem_dina), .cpu_hold(cpu_hold),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clka = ~clka;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write must follow an accepted byte, keep byte_ready low, and match the queue head.
  always begin
    @(negedge clka);
    #2;
    if (rsta && mem_wea) begin
      check("wr_ready_low", {31'd0, byte_ready}, 32'd0);
      check("wr_after_byte", {31'd0, prev_xfer}, 32'd1);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data %h expected no write", mem_addra, mem_dina);
      end else begin
        logic [ADDR_W+31:0] e;
        e = exp_q.pop_front();
        check("wr_addr", {{(32-ADDR_W){1'b0}}, mem_addra}, {{(32-ADDR_W){1'b0}}, e[ADDR_W+31:32]});
        check("wr_data", mem_dina, e[31:0]);
      end
    end
    prev_xfer = rsta && byte_valid && byte_ready;
  end

  // Called at a negedge; returns at the negedge after the byte was taken.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    if (gaps) begin
      byte_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clka);
    end
    byte_valid = 1'b1;
    byte_data  = b;
    n = 0;
    while (!byte_ready && n < 20) begin
      @(negedge clka);
      n++;
    end
    if (!byte_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL byte_timeout: got byte_ready 0 expected 1 for byte %h", b);
    end else begin
      @(negedge clka);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clka);
    start = 1'b0;
    check("start_busy", {31'd0, busy}, 32'd1);
    check("start_done", {31'd0, done}, 32'd0);
    check("start_err", {31'd0, err}, 32'd0);
    check("start_hold", {31'd0, cpu_hold}, 32'd1);
  endtask

  // mode 0: word = index, mode 1: random words, mode 2: single given word w0.
  task automatic do_load(input int n, input int mode, input logic [31:0] w0,
                         input bit bad, input bit gaps, input bit poke);
    logic [7:0] bytes[$];
    logic [7:0] chk;
    logic [31:0] w;
    bytes.push_back((n == DEPTH) ? 8'd0 : 8'(n));
    for (int i = 0; i < n; i++) begin
      w = (mode == 0) ? 32'(i) : (mode == 1) ? $urandom : w0;
      exp_q.push_back({ADDR_W'(i), w});
      for (int k = 3; k >= 0; k--) bytes.push_back(w[8*k +: 8]);
    end
    chk = 8'd0;
    foreach (bytes[i]) chk = chk ^ bytes[i];
    if (bad) chk = chk ^ 8'h07;
    pulse_start();
    foreach (bytes[i]) begin
      if (poke && i == 2) start = 1'b1;
      send_byte(bytes[i], gaps);
      start = 1'b0;
    end
    send_byte(chk, gaps);
    byte_valid = 1'b0;
    check("end_done", {31'd0, done}, {31'd0, !bad});
    check("end_err", {31'd0, err}, {31'd0, bad});
    check("end_hold", {31'd0, cpu_hold}, {31'd0, bad});
    check("end_busy", {31'd0, busy}, 32'd0);
    check("end_ready", {31'd0, byte_ready}, 32'd0);
  endtask

  initial begin
    rsta = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    #2 rsta = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_wea", {31'd0, mem_wea}, 32'd0);
    check("rst_ready", {31'd0, byte_ready}, 32'd0);
    check("rst_hold", {31'd0, cpu_hold}, 32'd1);
    check("rst_addr", {{(32-ADDR_W){1'b0}}, mem_addra}, 32'd0);
    check("rst_dina", mem_dina, 32'd0);
    @(negedge clka);
    rsta = 1'b1;
    byte_valid = 1'b1;
    byte_data  = 8'h55;
    repeat (3) @(negedge clka);
    check("idle_hold", {31'd0, cpu_hold}, 32'd1);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_ready", {31'd0, byte_ready}, 32'd0);
    byte_valid = 1'b0;

    do_load(1, 2, 32'h0022_1820, 1'b0, 1'b0, 1'b0);
    do_load(1, 2, 32'h0022_1820, 1'b1, 1'b0, 1'b0);
    do_load(DEPTH, 0, 32'd0, 1'b0, 1'b0, 1'b0);
    do_load(DEPTH, 0, 32'd0, 1'b0, 1'b1, 1'b0);
    do_load(3, 1, 32'd0, 1'b0, 1'b1, 1'b1);

    // Reset after two words have been written.
    pulse_start();
    send_byte(8'd4, 1'b0);
    for (int i = 0; i < 2; i++) begin
      logic [31:0] w;
      w = $urandom;
      exp_q.push_back({ADDR_W'(i), w});
      for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8], 1'b0);
    end
    byte_valid = 1'b0;
    @(posedge clka);
    #2 rsta = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_hold", {31'd0, cpu_hold}, 32'd1);
    check("mid_rst_ready", {31'd0, byte_ready}, 32'd0);
    check("mid_rst_wea", {31'd0, mem_wea}, 32'd0);
    @(negedge clka);
    rsta = 1'b1;
    @(negedge clka);
    do_load(DEPTH, 1, 32'd0, 1'b0, 1'b1, 1'b0);

    for (int t = 0; t < 6; t++) begin
      do_load($urandom_range(1, 8), 1, 32'd0, ($urandom_range(0, 3) == 0),
              $urandom_range(0, 1), $urandom_range(0, 1));
    end

    repeat (2) @(negedge clka);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
